// File: rtl/gates_pkg.sv
// Shared types and constants for the Gates demo input conditioner.
// Optional feature macro used by the files importing this package: GATES_EDGE_EN.
package gates_pkg;

   typedef enum logic {STABLE, SETTLING} deb_state_t;

   localparam int unsigned GATES_NUM_IN = 3;
   localparam int unsigned SYNC_MIN     = 2;
   localparam int unsigned SYNC_MAX     = 4;

endpackage

// File: rtl/gates_input_conditioner_if.sv
// Switch-side and gate-side signals of the input conditioner.
// master: the board / gate block around the conditioner; slave: the conditioner itself.
// rise/fall carry {c,b,a} edge pulses, active only when GATES_EDGE_EN is defined.
interface gates_input_conditioner_if import gates_pkg::*; ();

   logic                    sw_a;
   logic                    sw_b;
   logic                    sw_c;
   logic                    a;
   logic                    b;
   logic                    c;
   logic                    changed;
   logic [GATES_NUM_IN-1:0] rise;
   logic [GATES_NUM_IN-1:0] fall;

   modport master (
      output sw_a, sw_b, sw_c,
      input  a, b, c, changed, rise, fall
   );

   modport slave (
      input  sw_a, sw_b, sw_c,
      output a, b, c, changed, rise, fall
   );

endinterface

// File: rtl/gates_debounce_chan.sv
// One conditioning channel: synchroniser chain, debounce FSM with qualification
// counter, registered output level, flip flag and optional edge flags.
// Optional feature: GATES_EDGE_EN builds the rise/fall flops; otherwise they are tied to 0.
module gates_debounce_chan import gates_pkg::*; #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic out,
   output logic flip,
   output logic rise,
   output logic fall
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("gates_debounce_chan: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES at least 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   syn;
   deb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_q, out_d;
   logic                   flip_q;

   // Shift the raw switch through the synchroniser chain.
   // NOTE: the synchroniser flops are reset too, so a switch held high during reset
   // still needs the full latency after release instead of leaking straight through.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
   end

   assign syn = sync_q[SYNC_STAGES-1];

   // Debounce state, counter and output level registers.
   // NOTE: state is updated only with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         flip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         flip_q  <= (out_d != out_q);
      end
   end

   // Next-state logic: qualify a new level for DEBOUNCE_CYCLES, restart on any bounce.
   // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      unique case (state_q)
         STABLE: begin
            if (syn != out_q) begin
               state_d = SETTLING;
               cnt_d   = CNT_W'(1);
            end
         end
         SETTLING: begin
            if (syn == out_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = STABLE;
               cnt_d   = '0;
               out_d   = syn;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign out  = out_q;
   assign flip = flip_q;

`ifdef GATES_EDGE_EN
   logic rise_q;
   logic fall_q;

   // Edge flags, registered alongside flip so they coincide with the new level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= out_d & ~out_q;
         fall_q <= ~out_d & out_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/gates_input_conditioner.sv
// Conditions the three raw board switches into settled a/b/c levels for the gate block.
// Each switch gets its own independent synchroniser + debouncer channel; the top only
// merges the per-channel flips into a single changed pulse.
// Optional feature: GATES_EDGE_EN enables the rise/fall edge pulses.
module gates_input_conditioner import gates_pkg::*; #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   gates_input_conditioner_if.slave  bus
);

   logic [GATES_NUM_IN-1:0] sw;
   logic [GATES_NUM_IN-1:0] lvl;
   logic [GATES_NUM_IN-1:0] flip;
   logic [GATES_NUM_IN-1:0] rise;
   logic [GATES_NUM_IN-1:0] fall;

   assign sw = {bus.sw_c, bus.sw_b, bus.sw_a};

   for (genvar i = 0; i < GATES_NUM_IN; i++) begin : g_chan
      gates_debounce_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .sw   (sw[i]),
         .out  (lvl[i]),
         .flip (flip[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end

   assign bus.a       = lvl[0];
   assign bus.b       = lvl[1];
   assign bus.c       = lvl[2];
   assign bus.changed = |flip;
   assign bus.rise    = rise;
   assign bus.fall    = fall;

endmodule

// File: tb/tb_gates_input_conditioner.sv
// Directed bench for gates_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// (6-edge latency). Expected edge pulses follow GATES_EDGE_EN.
module tb_gates_input_conditioner;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   gates_input_conditioner_if bus ();

   gates_input_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] edge_exp(input logic [2:0] v);
`ifdef GATES_EDGE_EN
      return v;
`else
      return 3'b000;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [2:0] abc, input logic chg,
                             input logic [2:0] r, input logic [2:0] f);
      check({tag, ".cba"},    {bus.c, bus.b, bus.a}, abc);
      check({tag, ".changed"}, {2'b00, bus.changed}, {2'b00, chg});
      check({tag, ".rise"},   bus.rise, edge_exp(r));
      check({tag, ".fall"},   bus.fall, edge_exp(f));
   endtask

   task automatic set_sw(input logic [2:0] v);
      bus.sw_a = v[0];
      bus.sw_b = v[1];
      bus.sw_c = v[2];
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      set_sw(3'b000);
      step();
      check_outs("rst_pulse", 3'b000, 1'b0, 3'b000, 3'b000);
      rst = 1'b0;
   endtask

   initial begin
      // Scenario 1: reset held with all switches high.
      rst = 1'b1;
      set_sw(3'b111);
      for (int i = 0; i < 5; i++) begin
         step();
         check_outs("reset_hold", 3'b000, 1'b0, 3'b000, 3'b000);
      end
      pulse_reset();

      // Scenario 2: clean step on sw_a.
      set_sw(3'b001);
      for (int i = 0; i < 6; i++) begin
         step();
         check_outs("step_wait", 3'b000, 1'b0, 3'b000, 3'b000);
      end
      step();
      check_outs("step_rise", 3'b001, 1'b1, 3'b001, 3'b000);
      step();
      check_outs("step_after", 3'b001, 1'b0, 3'b000, 3'b000);

      // Scenario 3: sw_b bounces high 3, low 1, then high.
      set_sw(3'b011);
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs("bounce_hi", 3'b001, 1'b0, 3'b000, 3'b000);
      end
      set_sw(3'b001);
      step();
      check_outs("bounce_lo", 3'b001, 1'b0, 3'b000, 3'b000);
      set_sw(3'b011);
      for (int i = 0; i < 6; i++) begin
         step();
         check_outs("bounce_wait", 3'b001, 1'b0, 3'b000, 3'b000);
      end
      step();
      check_outs("bounce_rise", 3'b011, 1'b1, 3'b010, 3'b000);
      step();
      check_outs("bounce_after", 3'b011, 1'b0, 3'b000, 3'b000);

      // Scenario 4: sw_a and sw_c rise together, then sw_a falls.
      pulse_reset();
      set_sw(3'b101);
      for (int i = 0; i < 6; i++) begin
         step();
         check_outs("simul_wait", 3'b000, 1'b0, 3'b000, 3'b000);
      end
      step();
      check_outs("simul_rise", 3'b101, 1'b1, 3'b101, 3'b000);
      step();
      check_outs("simul_after", 3'b101, 1'b0, 3'b000, 3'b000);
      set_sw(3'b100);
      for (int i = 0; i < 6; i++) begin
         step();
         check_outs("fall_wait", 3'b101, 1'b0, 3'b000, 3'b000);
      end
      step();
      check_outs("fall_edge", 3'b100, 1'b1, 3'b000, 3'b001);
      step();
      check_outs("fall_after", 3'b100, 1'b0, 3'b000, 3'b000);

      // Scenario 5: reset during qualification of sw_c.
      pulse_reset();
      set_sw(3'b100);
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs("midrst_count", 3'b000, 1'b0, 3'b000, 3'b000);
      end
      rst = 1'b1;
      step();
      check_outs("midrst_rst", 3'b000, 1'b0, 3'b000, 3'b000);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check_outs("midrst_wait", 3'b000, 1'b0, 3'b000, 3'b000);
      end
      step();
      check_outs("midrst_rise", 3'b100, 1'b1, 3'b100, 3'b000);
      step();
      check_outs("midrst_after", 3'b100, 1'b0, 3'b000, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
